// File: rtl/hdu_ctrl_pkg.sv
// Shared types and helpers for the hazard detection / pipeline control unit.
//   hdu_state_e : FSM encoding (RUN waits for hazards, MD_WAIT holds the
//                 pipe while a multi-cycle mul/div is in flight)
//   src_hit     : one ID source operand matches the EXE destination
package hdu_ctrl_pkg;

  typedef enum logic {
    HDU_RUN     = 1'b0,
    HDU_MD_WAIT = 1'b1
  } hdu_state_e;

  function automatic logic src_hit(input logic re, input logic [31:0] raddr,
                                   input logic [31:0] waddr);
    return re && (raddr == waddr);
  endfunction

endpackage

// File: rtl/hdu_sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk_i  : clock
//   rst_ni : async active-low reset, clears the count
//   inc_i  : count this cycle
//   cnt_o  : current count, sticks at all-ones
module hdu_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))   cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/hdu_ctrl.sv
// Hazard detection and pipeline control for the five-stage RV32 core.
// Inputs : ID source regs, ID/EXE destination + load flag, EXE jump result,
//          mul/div start/done handshake.
// Outputs: PC / IF/ID / ID/EXE stall and flush, PC redirect + target,
//          stall-cycle and redirect-event counters.
// All control outputs are combinational from inputs and the state register.
module hdu_ctrl
  import hdu_ctrl_pkg::*;
#(
  parameter int RADDR_WIDTH = 5,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [RADDR_WIDTH-1:0] id_rs1_raddr_i,
  input  logic                   id_rs1_re_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_raddr_i,
  input  logic                   id_rs2_re_i,
  input  logic                   ex_reg_we_i,
  input  logic [RADDR_WIDTH-1:0] ex_reg_waddr_i,
  input  logic                   ex_is_load_i,
  input  logic                   ex_jump_i,
  input  logic [ADDR_WIDTH-1:0]  ex_jump_addr_i,
  input  logic                   md_start_i,
  input  logic                   md_done_i,
  output logic                   stall_pc_o,
  output logic                   stall_if_id_o,
  output logic                   stall_id_exe_o,
  output logic                   flush_if_id_o,
  output logic                   flush_id_exe_o,
  output logic                   redirect_o,
  output logic [ADDR_WIDTH-1:0]  redirect_addr_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o,
  output logic [CNT_WIDTH-1:0]   flush_cnt_o
);

  hdu_state_e state_q, state_d;
  logic       lu, md_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= HDU_RUN;
    else         state_q <= state_d;
  end

  // Load whose result is not ready yet feeds the instruction in ID.
  always_comb begin
    lu = ex_is_load_i && ex_reg_we_i && (ex_reg_waddr_i != '0) &&
         (src_hit(id_rs1_re_i, 32'(id_rs1_raddr_i), 32'(ex_reg_waddr_i)) ||
          src_hit(id_rs2_re_i, 32'(id_rs2_raddr_i), 32'(ex_reg_waddr_i)));
  end

  // A start with done in the same cycle is a single-cycle op: no stall.
  assign md_busy = (((state_q == HDU_RUN) && md_start_i) || (state_q == HDU_MD_WAIT))
                   && !md_done_i;

  always_comb begin
    state_d         = state_q;
    stall_pc_o      = 1'b0;
    stall_if_id_o   = 1'b0;
    stall_id_exe_o  = 1'b0;
    flush_if_id_o   = 1'b0;
    flush_id_exe_o  = 1'b0;
    redirect_o      = 1'b0;
    redirect_addr_o = '0;

    case (state_q)
      HDU_RUN:     if (md_start_i && !md_done_i) state_d = HDU_MD_WAIT;
      HDU_MD_WAIT: if (md_done_i)                state_d = HDU_RUN;
      default:                                   state_d = HDU_RUN;
    endcase

    // Outputs are held quiet throughout reset, even if inputs look active.
    if (rst_ni) begin
      if (md_busy) begin
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        stall_id_exe_o = 1'b1;
      end else if (ex_jump_i && (state_q == HDU_RUN)) begin
        // ID holds a wrong-path instruction, so the jump wins over lu.
        redirect_o      = 1'b1;
        redirect_addr_o = ex_jump_addr_i;
        flush_if_id_o   = 1'b1;
        flush_id_exe_o  = 1'b1;
      end else if (lu) begin
        // One bubble; the hazard clears once the load reaches MEM.
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        flush_id_exe_o = 1'b1;
      end
    end
  end

  hdu_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i (clk_i), .rst_ni(rst_ni), .inc_i(stall_pc_o), .cnt_o(stall_cnt_o)
  );

  hdu_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i (clk_i), .rst_ni(rst_ni), .inc_i(redirect_o), .cnt_o(flush_cnt_o)
  );

endmodule

// File: tb/tb_hdu_ctrl.sv
module tb_hdu_ctrl;
  import hdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1, rs2, waddr;
  logic        rs1_re, rs2_re, we, is_load, jump, md_start, md_done;
  logic [31:0] jump_addr;
  logic        s_pc, s_ifid, s_idex, f_ifid, f_idex, redir;
  logic [31:0] redir_addr, stall_cnt, flush_cnt;
  logic        x_s_pc, x_s_ifid, x_s_idex, x_f_ifid, x_f_idex, x_redir;
  logic [31:0] x_redir_addr;
  logic [2:0]  sat_stall_cnt, sat_flush_cnt;
  logic [5:0]  ctl;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign ctl = {s_pc, s_ifid, s_idex, f_ifid, f_idex, redir};

  hdu_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_raddr_i(rs1), .id_rs1_re_i(rs1_re),
    .id_rs2_raddr_i(rs2), .id_rs2_re_i(rs2_re),
    .ex_reg_we_i(we), .ex_reg_waddr_i(waddr), .ex_is_load_i(is_load),
    .ex_jump_i(jump), .ex_jump_addr_i(jump_addr),
    .md_start_i(md_start), .md_done_i(md_done),
    .stall_pc_o(s_pc), .stall_if_id_o(s_ifid), .stall_id_exe_o(s_idex),
    .flush_if_id_o(f_ifid), .flush_id_exe_o(f_idex),
    .redirect_o(redir), .redirect_addr_o(redir_addr),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  hdu_ctrl #(.CNT_WIDTH(3)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_raddr_i(rs1), .id_rs1_re_i(rs1_re),
    .id_rs2_raddr_i(rs2), .id_rs2_re_i(rs2_re),
    .ex_reg_we_i(we), .ex_reg_waddr_i(waddr), .ex_is_load_i(is_load),
    .ex_jump_i(jump), .ex_jump_addr_i(jump_addr),
    .md_start_i(md_start), .md_done_i(md_done),
    .stall_pc_o(x_s_pc), .stall_if_id_o(x_s_ifid), .stall_id_exe_o(x_s_idex),
    .flush_if_id_o(x_f_ifid), .flush_id_exe_o(x_f_idex),
    .redirect_o(x_redir), .redirect_addr_o(x_redir_addr),
    .stall_cnt_o(sat_stall_cnt), .flush_cnt_o(sat_flush_cnt)
  );

  // A jump while mul/div occupies EXE is illegal stimulus.
  always @(negedge clk)
    if (rst_n) assert (!(dut.state_q == HDU_MD_WAIT && jump))
      else $error("illegal jump during MD_WAIT");

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; waddr = 5'd0;
    rs1_re = 1'b0; rs2_re = 1'b0; we = 1'b0; is_load = 1'b0;
    jump = 1'b0; jump_addr = 32'h0; md_start = 1'b0; md_done = 1'b0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #13 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    md_start = 1'b1; jump = 1'b1; jump_addr = 32'hdead_beef;
    #2;
    n_chk++; if (ctl !== 6'b0 || redir_addr !== 32'h0) begin n_fail++;
      $display("FAIL reset_outputs: got ctl=%b addr=%h, want 0/0", ctl, redir_addr); end
    n_chk++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_fail++;
      $display("FAIL reset_counters: got %0d/%0d, want 0/0", stall_cnt, flush_cnt); end
    n_chk++; if (dut.state_q !== HDU_RUN) begin n_fail++;
      $display("FAIL reset_state: got %0d, want RUN", dut.state_q); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    is_load = 1'b1; we = 1'b1; waddr = 5'd5; rs1 = 5'd5; rs1_re = 1'b1; rs2 = 5'd7;
    #1;
    n_chk++; if (ctl !== 6'b110010) begin n_fail++;
      $display("FAIL lu_ctl: got %b, want 110010", ctl); end
    tick();
    is_load = 1'b0; waddr = 5'd0; // load moved on to MEM
    #1;
    n_chk++; if (ctl !== 6'b0) begin n_fail++;
      $display("FAIL lu_clears: got %b, want 000000", ctl); end
    n_chk++; if (stall_cnt !== 32'd1) begin n_fail++;
      $display("FAIL lu_stall_cnt: got %0d, want 1", stall_cnt); end
    is_load = 1'b1; waddr = 5'd0; rs1 = 5'd0;
    #1;
    n_chk++; if (ctl !== 6'b0) begin n_fail++;
      $display("FAIL lu_x0: got %b, want 000000", ctl); end
    waddr = 5'd5; rs1 = 5'd5; rs1_re = 1'b0;
    #1;
    n_chk++; if (ctl !== 6'b0) begin n_fail++;
      $display("FAIL lu_no_re: got %b, want 000000", ctl); end
    rs2 = 5'd5; rs2_re = 1'b1;
    #1;
    n_chk++; if (ctl !== 6'b110010) begin n_fail++;
      $display("FAIL lu_rs2: got %b, want 110010", ctl); end
    idle_inputs();
  endtask

  task automatic test_jump();
    do_reset();
    is_load = 1'b1; we = 1'b1; waddr = 5'd5; rs1 = 5'd5; rs1_re = 1'b1;
    jump = 1'b1; jump_addr = 32'h0000_0100;
    #1;
    n_chk++; if (ctl !== 6'b000111) begin n_fail++;
      $display("FAIL jump_ctl: got %b, want 000111", ctl); end
    n_chk++; if (redir_addr !== 32'h0000_0100) begin n_fail++;
      $display("FAIL jump_addr: got %h, want 00000100", redir_addr); end
    tick();
    idle_inputs(); jump_addr = 32'h0000_0200;
    #1;
    n_chk++; if (redir_addr !== 32'h0) begin n_fail++;
      $display("FAIL jump_addr_idle: got %h, want 0", redir_addr); end
    n_chk++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin n_fail++;
      $display("FAIL jump_cnts: got flush=%0d stall=%0d, want 1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_md_multi();
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      md_start = (c == 0);
      md_done  = (c == 4);
      #1;
      n_chk++; if (ctl !== ((c < 4) ? 6'b111000 : 6'b000000)) begin n_fail++;
        $display("FAIL md_ctl_c%0d: got %b, want %b", c, ctl, (c < 4) ? 6'b111000 : 6'b000000); end
      tick();
    end
    idle_inputs();
    #1;
    n_chk++; if (dut.state_q !== HDU_RUN) begin n_fail++;
      $display("FAIL md_state_back: got %0d, want RUN", dut.state_q); end
    n_chk++; if (stall_cnt !== 32'd4) begin n_fail++;
      $display("FAIL md_stall_cnt: got %0d, want 4", stall_cnt); end
  endtask

  task automatic test_md_single();
    do_reset();
    md_start = 1'b1; md_done = 1'b1;
    #1;
    n_chk++; if (ctl !== 6'b0) begin n_fail++;
      $display("FAIL md1_ctl: got %b, want 000000", ctl); end
    tick();
    idle_inputs();
    #1;
    n_chk++; if (dut.state_q !== HDU_RUN || stall_cnt !== 32'd0) begin n_fail++;
      $display("FAIL md1_state_cnt: got state=%0d cnt=%0d, want RUN/0", dut.state_q, stall_cnt); end
  endtask

  task automatic test_reset_mid_md();
    do_reset();
    md_start = 1'b1;
    tick(); md_start = 1'b0;
    tick();
    #3 rst_n = 1'b0;             // between edges
    #1;
    n_chk++; if (ctl !== 6'b0 || stall_cnt !== 32'd0 || dut.state_q !== HDU_RUN) begin n_fail++;
      $display("FAIL rst_mid: got ctl=%b cnt=%0d state=%0d, want 0/0/RUN", ctl, stall_cnt, dut.state_q); end
    #6 rst_n = 1'b1;             // released mid-cycle, 1 cycle low
    tick();
    md_start = 1'b1;
    #1;
    n_chk++; if (ctl !== 6'b111000) begin n_fail++;
      $display("FAIL rst_fresh_md: got %b, want 111000", ctl); end
    tick(); md_start = 1'b0; md_done = 1'b1;
    #1;
    n_chk++; if (ctl !== 6'b0) begin n_fail++;
      $display("FAIL rst_fresh_done: got %b, want 000000", ctl); end
    tick(); idle_inputs();
    #1;
    n_chk++; if (stall_cnt !== 32'd1 || dut.state_q !== HDU_RUN) begin n_fail++;
      $display("FAIL rst_fresh_cnt: got cnt=%0d state=%0d, want 1/RUN", stall_cnt, dut.state_q); end
  endtask

  task automatic test_saturation();
    do_reset();
    md_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(); md_start = 1'b0;
    end
    #1;
    n_chk++; if (stall_cnt !== 32'd10) begin n_fail++;
      $display("FAIL sat_wide: got %0d, want 10", stall_cnt); end
    n_chk++; if (sat_stall_cnt !== 3'd7) begin n_fail++;
      $display("FAIL sat_narrow: got %0d, want 7", sat_stall_cnt); end
    md_done = 1'b1;
    tick(); idle_inputs();
    #1;
    n_chk++; if (sat_stall_cnt !== 3'd7 || dut_sat.state_q !== HDU_RUN) begin n_fail++;
      $display("FAIL sat_hold: got %0d state=%0d, want 7/RUN", sat_stall_cnt, dut_sat.state_q); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_jump();
    test_md_multi();
    test_md_single();
    test_reset_mid_md();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, want finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
